// File: rtl/usb_bus_ctrl.sv
// Bus-level USB full-speed sequencer: decodes line state for reset, suspend and host
// resume, drives remote-wakeup K and arbitrates the PHY transmit pins.
module usb_bus_ctrl #(
    parameter int RST_CYC    = 120,
    parameter int SUSP_CYC   = 144000,
    parameter int WAIT_CYC   = 240000,
    parameter int RESUME_CYC = 480000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_dp,
    input  logic rx_dn,
    input  logic pkt_tx_dp,
    input  logic pkt_tx_dn,
    input  logic pkt_tx_en,
    input  logic wakeup_en,
    input  logic wakeup_req,
    output logic tx_dp,
    output logic tx_dn,
    output logic tx_en,
    output logic bus_reset,
    output logic bus_reset_stb,
    output logic suspend,
    output logic resume_stb,
    output logic wakeup_busy,
    output logic wakeup_done_stb
);

    typedef enum logic [1:0] {
        S_ACTIVE  = 2'd0,
        S_RESET   = 2'd1,
        S_SUSPEND = 2'd2,
        S_WAKE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_RST_MAX     = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] L_RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] L_SUSP_LAST   = CNT_W'(SUSP_CYC - 1);
    localparam logic [CNT_W-1:0] L_WAIT        = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] L_RESUME_LAST = CNT_W'(RESUME_CYC - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_se0_cnt;
    logic [CNT_W-1:0] w_next_se0_cnt;
    logic             r_nonj_prev;
    logic             r_tx_dp;
    logic             r_tx_dn;
    logic             r_tx_en;
    logic             r_bus_reset_stb;
    logic             r_resume_stb;
    logic             r_wakeup_done_stb;
    logic             w_j;
    logic             w_se0;
    logic             w_idle;
    logic             w_tx_dp;
    logic             w_tx_dn;
    logic             w_tx_en;

    assign w_j    = rx_dp & ~rx_dn;
    assign w_se0  = ~rx_dp & ~rx_dn;
    assign w_idle = w_j & ~pkt_tx_en;

    // SE0 run length survives SUSPEND->ACTIVE so a long SE0 resolves to a reset
    always_comb begin
        w_next_se0_cnt = '0;
        if (r_state != S_WAKE && w_se0) begin
            w_next_se0_cnt = (r_se0_cnt < L_RST_MAX) ? r_se0_cnt + 1'b1 : r_se0_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_ACTIVE: begin
                if (w_se0 && r_se0_cnt >= L_RST_LAST) begin
                    w_next_state = S_RESET;
                    w_next_cnt   = '0;
                end else if (w_idle && r_cnt >= L_SUSP_LAST) begin
                    w_next_state = S_SUSPEND;
                    w_next_cnt   = '0;
                end else if (w_idle) begin
                    w_next_cnt = r_cnt + 1'b1;
                end else begin
                    w_next_cnt = '0;
                end
            end
            S_RESET: begin
                w_next_cnt = '0;
                if (!w_se0) begin
                    w_next_state = S_ACTIVE;
                end
            end
            S_SUSPEND: begin
                if (!w_j && r_nonj_prev) begin
                    w_next_state = S_ACTIVE;
                    w_next_cnt   = '0;
                end else if (wakeup_req && wakeup_en && r_cnt >= L_WAIT && w_j) begin
                    w_next_state = S_WAKE;
                    w_next_cnt   = '0;
                end else if (r_cnt < L_WAIT) begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_WAKE: begin
                if (r_cnt >= L_RESUME_LAST) begin
                    w_next_state = S_ACTIVE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_ACTIVE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Mux keyed on the upcoming state so tx_en tracks WAKE_DRIVE cycle-exactly
    always_comb begin
        w_tx_dp = 1'b0;
        w_tx_dn = 1'b0;
        w_tx_en = 1'b0;
        case (w_next_state)
            S_ACTIVE: begin
                w_tx_dp = pkt_tx_dp;
                w_tx_dn = pkt_tx_dn;
                w_tx_en = pkt_tx_en;
            end
            S_WAKE: begin
                w_tx_dn = 1'b1;
                w_tx_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_ACTIVE;
            r_cnt             <= '0;
            r_se0_cnt         <= '0;
            r_nonj_prev       <= 1'b0;
            r_tx_dp           <= 1'b0;
            r_tx_dn           <= 1'b0;
            r_tx_en           <= 1'b0;
            r_bus_reset_stb   <= 1'b0;
            r_resume_stb      <= 1'b0;
            r_wakeup_done_stb <= 1'b0;
        end else begin
            r_state           <= w_next_state;
            r_cnt             <= w_next_cnt;
            r_se0_cnt         <= w_next_se0_cnt;
            r_nonj_prev       <= ~w_j;
            r_tx_dp           <= w_tx_dp;
            r_tx_dn           <= w_tx_dn;
            r_tx_en           <= w_tx_en;
            r_bus_reset_stb   <= (r_state != S_RESET) && (w_next_state == S_RESET);
            r_resume_stb      <= (r_state == S_SUSPEND) && (w_next_state == S_ACTIVE);
            r_wakeup_done_stb <= (r_state == S_WAKE) && (w_next_state == S_ACTIVE);
        end
    end

    assign tx_dp           = r_tx_dp;
    assign tx_dn           = r_tx_dn;
    assign tx_en           = r_tx_en;
    assign bus_reset       = (r_state == S_RESET);
    assign bus_reset_stb   = r_bus_reset_stb;
    assign suspend         = (r_state == S_SUSPEND) || (r_state == S_WAKE);
    assign resume_stb      = r_resume_stb;
    assign wakeup_busy     = (r_state == S_WAKE);
    assign wakeup_done_stb = r_wakeup_done_stb;

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Self-checking bench for usb_bus_ctrl: directed scenarios plus randomized line
// traffic compared every cycle against a run-length based reference model.
module tb_usb_bus_ctrl;

    localparam int RST    = 8;
    localparam int SUSP   = 32;
    localparam int WAIT   = 16;
    localparam int RESUME = 40;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    localparam int M_ACTIVE  = 0;
    localparam int M_RESET   = 1;
    localparam int M_SUSPEND = 2;
    localparam int M_WAKE    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxDp = 1'b1;
    logic rxDn = 1'b0;
    logic pktTxDp = 1'b0;
    logic pktTxDn = 1'b0;
    logic pktTxEn = 1'b0;
    logic wakeupEn = 1'b0;
    logic wakeupReq = 1'b0;

    logic tx_dp, tx_dn, tx_en, bus_reset, bus_reset_stb, suspend;
    logic resume_stb, wakeup_busy, wakeup_done_stb;
    logic [8:0] dutOut;
    logic [8:0] expOut;

    int total = 0;
    int bad = 0;

    // reference model state: run lengths and ages rather than counters
    int mMode, mIdleRun, mSe0Run, mSuspAge, mDriveAge;
    bit mPrevNonJ;

    always #5 clk = ~clk;

    usb_bus_ctrl #(
        .RST_CYC(RST), .SUSP_CYC(SUSP), .WAIT_CYC(WAIT), .RESUME_CYC(RESUME), .CNT_W(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_dp(rxDp), .rx_dn(rxDn),
        .pkt_tx_dp(pktTxDp), .pkt_tx_dn(pktTxDn), .pkt_tx_en(pktTxEn),
        .wakeup_en(wakeupEn), .wakeup_req(wakeupReq),
        .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_en(tx_en),
        .bus_reset(bus_reset), .bus_reset_stb(bus_reset_stb), .suspend(suspend),
        .resume_stb(resume_stb), .wakeup_busy(wakeup_busy), .wakeup_done_stb(wakeup_done_stb)
    );

    assign dutOut = {tx_dp, tx_dn, tx_en, bus_reset, bus_reset_stb, suspend,
                     resume_stb, wakeup_busy, wakeup_done_stb};

    task automatic model_reset;
        mMode = M_ACTIVE;
        mIdleRun = 0;
        mSe0Run = 0;
        mSuspAge = 0;
        mDriveAge = 0;
        mPrevNonJ = 1'b0;
        expOut = '0;
    endtask

    task automatic model_step(input logic [1:0] line);
        bit j, se0, rs, rss, ds;
        int newMode;
        logic [2:0] tx;
        j = (line == LJ);
        se0 = (line == LSE0);
        rs = 0; rss = 0; ds = 0;
        newMode = mMode;
        mSe0Run = (mMode == M_WAKE) ? 0 : (se0 ? mSe0Run + 1 : 0);
        case (mMode)
            M_ACTIVE: begin
                mIdleRun = (j && !pktTxEn) ? mIdleRun + 1 : 0;
                if (se0 && mSe0Run >= RST) begin
                    newMode = M_RESET; rs = 1;
                end else if (mIdleRun >= SUSP) begin
                    newMode = M_SUSPEND; mSuspAge = 0;
                end
            end
            M_RESET: if (!se0) newMode = M_ACTIVE;
            M_SUSPEND: begin
                if (!j && mPrevNonJ) begin
                    newMode = M_ACTIVE; rss = 1;
                end else if (wakeupReq && wakeupEn && mSuspAge >= WAIT && j) begin
                    newMode = M_WAKE; mDriveAge = 0;
                end else begin
                    mSuspAge++;
                end
            end
            default: begin
                mDriveAge++;
                if (mDriveAge == RESUME) begin
                    newMode = M_ACTIVE; ds = 1;
                end
            end
        endcase
        if (newMode == M_ACTIVE && mMode != M_ACTIVE) mIdleRun = 0;
        mPrevNonJ = !j;
        mMode = newMode;
        if (newMode == M_ACTIVE) tx = {pktTxDp, pktTxDn, pktTxEn};
        else if (newMode == M_WAKE) tx = 3'b011;
        else tx = 3'b000;
        expOut = {tx, newMode == M_RESET, rs, newMode == M_SUSPEND || newMode == M_WAKE,
                  rss, newMode == M_WAKE, ds};
    endtask

    task automatic step(input logic [1:0] line);
        rxDp = line[1];
        rxDn = line[0];
        @(posedge clk);
        #1;
        model_step(line);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        rxDp = 1'b1; rxDn = 1'b0;
        pktTxDp = 1'b0; pktTxDn = 1'b0; pktTxEn = 1'b0;
        wakeupEn = 1'b0; wakeupReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        pktTxDp = 1'b1; pktTxDn = 1'b1; pktTxEn = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (dutOut !== 9'b0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%b exp=%b", dutOut, 9'b0);
        end
        do_reset();
    endtask

    task automatic test_suspend;
        do_reset();
        repeat (SUSP - 1) step(LJ);
        total++;
        if (suspend !== 1'b0) begin bad++; $display("[TB] FAIL susp_early got=%b exp=0", suspend); end
        step(LJ);
        total++;
        if (suspend !== 1'b1) begin bad++; $display("[TB] FAIL susp_at_32 got=%b exp=1", suspend); end

        do_reset();
        repeat (20) step(LJ);
        step(LK);
        repeat (SUSP - 1) step(LJ);
        total++;
        if (suspend !== 1'b0) begin bad++; $display("[TB] FAIL susp_k_restart got=%b exp=0", suspend); end
        step(LJ);
        total++;
        if (suspend !== 1'b1) begin bad++; $display("[TB] FAIL susp_after_restart got=%b exp=1", suspend); end

        do_reset();
        pktTxEn = 1'b1;
        repeat (100) step(LJ);
        total++;
        if (suspend !== 1'b0 || tx_en !== 1'b1) begin
            bad++; $display("[TB] FAIL susp_blocked_by_tx susp=%b tx_en=%b exp susp=0 tx_en=1", suspend, tx_en);
        end
    endtask

    task automatic test_bus_reset;
        bit sawReset;
        int pulses;
        do_reset();
        step(LJ); step(LJ);
        sawReset = 0;
        repeat (RST - 1) begin step(LSE0); sawReset |= (bus_reset | bus_reset_stb); end
        step(LJ);
        sawReset |= (bus_reset | bus_reset_stb);
        total++;
        if (sawReset !== 1'b0) begin bad++; $display("[TB] FAIL se0_7_no_reset got=%b exp=0", sawReset); end

        repeat (RST - 1) step(LSE0);
        total++;
        if (bus_reset_stb !== 1'b0) begin bad++; $display("[TB] FAIL rst_stb_early got=%b exp=0", bus_reset_stb); end
        step(LSE0);
        total++;
        if (bus_reset_stb !== 1'b1 || bus_reset !== 1'b1) begin
            bad++; $display("[TB] FAIL rst_at_8 stb=%b rst=%b exp 1 1", bus_reset_stb, bus_reset);
        end
        pulses = 0;
        repeat (5) begin step(LSE0); pulses += bus_reset_stb; end
        total++;
        if (pulses != 0 || bus_reset !== 1'b1) begin
            bad++; $display("[TB] FAIL rst_hold pulses=%0d rst=%b exp 0 1", pulses, bus_reset);
        end
        step(LJ);
        total++;
        if (bus_reset !== 1'b0 || suspend !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_exit rst=%b susp=%b exp 0 0", bus_reset, suspend);
        end
    endtask

    task automatic test_resume;
        bit sawStb;
        do_reset();
        repeat (SUSP) step(LJ);
        step(LK);
        sawStb = resume_stb;
        repeat (3) begin step(LJ); sawStb |= resume_stb; end
        total++;
        if (suspend !== 1'b1 || sawStb !== 1'b0) begin
            bad++; $display("[TB] FAIL glitch_ignored susp=%b stb=%b exp 1 0", suspend, sawStb);
        end
        step(LK);
        total++;
        if (resume_stb !== 1'b0 || suspend !== 1'b1) begin
            bad++; $display("[TB] FAIL resume_k1 stb=%b susp=%b exp 0 1", resume_stb, suspend);
        end
        step(LK);
        total++;
        if (resume_stb !== 1'b1 || suspend !== 1'b0) begin
            bad++; $display("[TB] FAIL resume_k2 stb=%b susp=%b exp 1 0", resume_stb, suspend);
        end
        step(LJ);
        total++;
        if (resume_stb !== 1'b0) begin bad++; $display("[TB] FAIL resume_stb_width got=%b exp=0", resume_stb); end

        do_reset();
        repeat (SUSP) step(LJ);
        step(LSE0);
        step(LSE0);
        total++;
        if (resume_stb !== 1'b1) begin bad++; $display("[TB] FAIL se0_resume got=%b exp=1", resume_stb); end
        sawStb = 0;
        repeat (RST - 3) begin step(LSE0); sawStb |= bus_reset_stb; end
        total++;
        if (sawStb !== 1'b0) begin bad++; $display("[TB] FAIL se0_rst_early got=%b exp=0", sawStb); end
        step(LSE0);
        total++;
        if (bus_reset_stb !== 1'b1) begin bad++; $display("[TB] FAIL se0_rst_8th got=%b exp=1", bus_reset_stb); end
    endtask

    task automatic test_wakeup;
        int hi;
        bit fell, sawBusy;
        do_reset();
        wakeupEn = 1'b1;
        repeat (SUSP) step(LJ);
        for (int k = 0; k < WAIT; k++) begin
            if (k == 5) wakeupReq = 1'b1;
            step(LJ);
        end
        total++;
        if (wakeup_busy !== 1'b0 || tx_en !== 1'b0) begin
            bad++; $display("[TB] FAIL wake_too_early busy=%b tx_en=%b exp 0 0", wakeup_busy, tx_en);
        end
        step(LJ);
        total++;
        if ({tx_dp, tx_dn, tx_en, wakeup_busy, suspend} !== 5'b01111) begin
            bad++; $display("[TB] FAIL wake_start got=%b exp=01111", {tx_dp, tx_dn, tx_en, wakeup_busy, suspend});
        end
        wakeupReq = 1'b0;
        hi = 1;
        fell = 0;
        for (int i = 0; i < 100 && !fell; i++) begin
            step(LK);
            if (tx_en === 1'b1 && tx_dn === 1'b1 && tx_dp === 1'b0) hi++;
            else fell = 1;
        end
        total++;
        if (!fell || hi != RESUME) begin
            bad++; $display("[TB] FAIL wake_len got=%0d exp=%0d ended=%0d", hi, RESUME, fell);
        end
        total++;
        if (wakeup_done_stb !== 1'b1 || suspend !== 1'b0 || wakeup_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL wake_done stb=%b susp=%b busy=%b exp 1 0 0",
                            wakeup_done_stb, suspend, wakeup_busy);
        end
        step(LJ);
        total++;
        if (wakeup_done_stb !== 1'b0) begin bad++; $display("[TB] FAIL wake_done_width got=%b exp=0", wakeup_done_stb); end

        do_reset();
        wakeupEn = 1'b0;
        wakeupReq = 1'b1;
        repeat (SUSP) step(LJ);
        sawBusy = 0;
        repeat (40) begin step(LJ); sawBusy |= (wakeup_busy | tx_en); end
        total++;
        if (sawBusy !== 1'b0 || suspend !== 1'b1) begin
            bad++; $display("[TB] FAIL wake_disabled busy=%b susp=%b exp 0 1", sawBusy, suspend);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        wakeupEn = 1'b1;
        wakeupReq = 1'b1;
        repeat (SUSP + WAIT + 1) step(LJ);
        repeat (5) step(LK);
        total++;
        if (wakeup_busy !== 1'b1 || tx_en !== 1'b1) begin
            bad++; $display("[TB] FAIL async_pre busy=%b tx_en=%b exp 1 1", wakeup_busy, tx_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dutOut !== 9'b0) begin bad++; $display("[TB] FAIL async_clear got=%b exp=%b", dutOut, 9'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        wakeupReq = 1'b0;
        model_reset();
        step(LJ);
        total++;
        if (suspend !== 1'b0 || bus_reset !== 1'b0 || tx_en !== 1'b0) begin
            bad++; $display("[TB] FAIL async_release susp=%b rst=%b tx_en=%b exp 0 0 0", suspend, bus_reset, tx_en);
        end
    endtask

    task automatic test_passthrough;
        logic [2:0] v, prev;
        do_reset();
        prev = 3'b000;
        for (int i = 0; i < 12; i++) begin
            v = 3'($urandom_range(0, 7));
            {pktTxDp, pktTxDn, pktTxEn} = v;
            #1;
            total++;
            if ({tx_dp, tx_dn, tx_en} !== prev) begin
                bad++; $display("[TB] FAIL pass_lag got=%b exp=%b", {tx_dp, tx_dn, tx_en}, prev);
            end
            step(LK);
            total++;
            if ({tx_dp, tx_dn, tx_en} !== v) begin
                bad++; $display("[TB] FAIL pass_value got=%b exp=%b", {tx_dp, tx_dn, tx_en}, v);
            end
            prev = v;
        end
    endtask

    task automatic test_random;
        int kind, len;
        logic [1:0] line;
        bit enFixed, enVal;
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            kind = $urandom_range(0, 9);
            wakeupEn = ($urandom_range(0, 3) != 0);
            enFixed = 1; enVal = 0;
            if (kind <= 4) begin line = LJ; len = $urandom_range(1, 40); end
            else if (kind <= 6) begin line = LK; len = $urandom_range(1, 3); enFixed = 0; end
            else if (kind == 7) begin line = LSE0; len = $urandom_range(1, 10); enFixed = 0; end
            else if (kind == 8) begin line = LSE1; len = $urandom_range(1, 2); enFixed = 0; end
            else begin line = LJ; len = $urandom_range(1, 10); enVal = 1; end
            for (int i = 0; i < len; i++) begin
                pktTxDp = 1'($urandom_range(0, 1));
                pktTxDn = 1'($urandom_range(0, 1));
                pktTxEn = enFixed ? enVal : 1'($urandom_range(0, 1));
                wakeupReq = 1'($urandom_range(0, 1));
                step(line);
                total++;
                if (dutOut !== expOut) begin
                    bad++; $display("[TB] FAIL random seg=%0d got=%b exp=%b", seg, dutOut, expOut);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_suspend();
        test_bus_reset();
        test_resume();
        test_wakeup();
        test_async_reset();
        test_passthrough();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
